// File: rtl/register_file_pkg.sv
// Shared types and default sizes for the multi-port register file.
package register_file_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: after reset walks clr_addr over every entry, one per clock,
// holding busy high until the last entry has been zeroed.
module rf_clear_seq
    import register_file_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output rf_state_t         state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    rf_state_t         state_q;
    logic [ADDR_W-1:0] clr_idx_q;

    // Reset restarts the sweep from entry 0 even when it lands mid-sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= RF_READY;
                    end
                end
                RF_READY: begin
                    clr_idx_q <= clr_idx_q;
                end
                default: begin
                    state_q   <= RF_CLEAR;
                    clr_idx_q <= '0;
                end
            endcase
        end
    end

    assign busy      = (state_q == RF_CLEAR);
    assign clr_we    = busy;
    assign clr_addr  = clr_idx_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised register file: two write ports (port 1 wins on a clash), N_READ
// combinational read ports with optional bypass and hardwired zero entry.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wr0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wr1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [N_READ*ADDR_W-1:0] ra,
    output logic [N_READ*DATA_W-1:0] rd,
    output logic                     busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    rf_state_t         seq_state;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .state_dbg (seq_state)
    );

    logic wr0_ok;
    logic wr1_ok;

    assign wr0_ok = we0 && !((ZERO_REG != 0) && (wr0 == '0));
    assign wr1_ok = we1 && !((ZERO_REG != 0) && (wr1 == '0));

    // Port 1 is assigned last so it overrides port 0 on the same address.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else begin
            if (wr0_ok) begin
                mem_q[wr0] <= wd0;
            end
            if (wr1_ok) begin
                mem_q[wr1] <= wd1;
            end
        end
    end

    for (genvar k = 0; k < N_READ; k++) begin : g_read
        logic [ADDR_W-1:0] ra_k;
        logic [DATA_W-1:0] rd_k;

        assign ra_k = ra[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_k = mem_q[ra_k];
            if (busy) begin
                rd_k = '0;
            end else if ((ZERO_REG != 0) && (ra_k == '0)) begin
                rd_k = '0;
            end else if ((BYPASS != 0) && (seq_state == RF_READY) && we1 && (wr1 == ra_k)) begin
                rd_k = wd1;
            end else if ((BYPASS != 0) && (seq_state == RF_READY) && we0 && (wr0 == ra_k)) begin
                rd_k = wd0;
            end
        end

        assign rd[k*DATA_W +: DATA_W] = rd_k;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default, no-bypass, zero-register and
// small four-read-port configurations driven side by side.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1;
    logic [4:0]  wr0, wr1;
    logic [31:0] wd0, wd1;
    logic [9:0]  ra;
    logic [63:0] rd_a, rd_b, rd_c;
    logic        busy_a, busy_b, busy_c;

    logic        we0_d, we1_d;
    logic [2:0]  wr0_d, wr1_d;
    logic [31:0] wd0_d, wd1_d;
    logic [11:0] ra_d;
    logic [127:0] rd_d;
    logic        busy_d;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          na, nb, nc, nd;

    always #5 clk = ~clk;

    register_file_mp dut_a (
        .clk(clk), .rst(rst), .we0(we0), .wr0(wr0), .wd0(wd0),
        .we1(we1), .wr1(wr1), .wd1(wd1), .ra(ra), .rd(rd_a), .busy(busy_a)
    );

    register_file_mp #(.BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .we0(we0), .wr0(wr0), .wd0(wd0),
        .we1(we1), .wr1(wr1), .wd1(wd1), .ra(ra), .rd(rd_b), .busy(busy_b)
    );

    register_file_mp #(.ZERO_REG(1)) dut_c (
        .clk(clk), .rst(rst), .we0(we0), .wr0(wr0), .wd0(wd0),
        .we1(we1), .wr1(wr1), .wd1(wd1), .ra(ra), .rd(rd_c), .busy(busy_c)
    );

    register_file_mp #(.ADDR_W(3), .N_READ(4)) dut_d (
        .clk(clk), .rst(rst), .we0(we0_d), .wr0(wr0_d), .wd0(wd0_d),
        .we1(we1_d), .wr1(wr1_d), .wd1(wd1_d), .ra(ra_d), .rd(rd_d), .busy(busy_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: observed=%h but no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
            end
        end
    endtask

    // Counts cycles each instance stays busy; bounded so a stuck sweep still ends.
    task automatic count_busy(output int ca, output int cb, output int cc, output int cd);
        ca = 0; cb = 0; cc = 0; cd = 0;
        for (int i = 0; i < 200; i++) begin
            if (!(busy_a === 1'b1 || busy_b === 1'b1 || busy_c === 1'b1 || busy_d === 1'b1)) break;
            if (busy_a === 1'b1) ca++;
            if (busy_b === 1'b1) cb++;
            if (busy_c === 1'b1) cc++;
            if (busy_d === 1'b1) cd++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        we0 = 1'b0; we1 = 1'b0; wr0 = '0; wr1 = '0; wd0 = '0; wd1 = '0; ra = '0;
        we0_d = 1'b0; we1_d = 1'b0; wr0_d = '0; wr1_d = '0; wd0_d = '0; wd1_d = '0; ra_d = '0;

        // Reset pulse and first sweep
        tick();
        rst = 1'b0;
        ra = {5'd9, 5'd4};
        #1;
        expect_v(32'd1); check("busy_after_rst", {31'b0, busy_a});
        expect_v(32'd1); check("busy_d_after_rst", {31'b0, busy_d});
        expect_v(32'd0); check("rd_during_sweep", rd_a[31:0]);
        count_busy(na, nb, nc, nd);
        expect_v(32'd32); check("sweep_len_a", na);
        expect_v(32'd32); check("sweep_len_b", nb);
        expect_v(32'd32); check("sweep_len_c", nc);
        expect_v(32'd8);  check("sweep_len_d", nd);

        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #1;
            expect_v(32'd0); check("cleared_p0", rd_a[31:0]);
            expect_v(32'd0); check("cleared_p1", rd_a[63:32]);
        end

        // Basic write on port 0
        we0 = 1'b1; wr0 = 5'd3; wd0 = 32'h0000_0003;
        tick();
        we0 = 1'b0; ra = {5'd2, 5'd3};
        #1;
        expect_v(32'h0000_0003); check("basic_rd0", rd_a[31:0]);
        expect_v(32'h0000_0000); check("basic_rd1", rd_a[63:32]);

        // Both ports hit entry 7
        we0 = 1'b1; we1 = 1'b1; wr0 = 5'd7; wr1 = 5'd7;
        wd0 = 32'hAAAA_AAAA; wd1 = 32'h5555_5555; ra = {5'd3, 5'd7};
        #1;
        expect_v(32'h5555_5555); check("conflict_bypass_a", rd_a[31:0]);
        expect_v(32'h0000_0000); check("conflict_nobypass_b", rd_b[31:0]);
        expect_v(32'h0000_0003); check("conflict_other_port", rd_a[63:32]);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        expect_v(32'h5555_5555); check("conflict_stored_a", rd_a[31:0]);
        expect_v(32'h5555_5555); check("conflict_stored_b", rd_b[31:0]);

        // Independent writes on both ports
        we0 = 1'b1; wr0 = 5'd10; wd0 = 32'h1357_9BDF;
        we1 = 1'b1; wr1 = 5'd11; wd1 = 32'h2468_ACE0;
        tick();
        we0 = 1'b0; we1 = 1'b0; ra = {5'd11, 5'd10};
        #1;
        expect_v(32'h1357_9BDF); check("dual_wr_p0", rd_b[31:0]);
        expect_v(32'h2468_ACE0); check("dual_wr_p1", rd_b[63:32]);

        // Same-cycle read of entry 2 with and without bypass
        we0 = 1'b1; wr0 = 5'd2; wd0 = 32'hF0F0_F0F0; ra = {5'd0, 5'd2};
        #1;
        expect_v(32'h0000_0000); check("nobypass_same_cycle", rd_b[31:0]);
        expect_v(32'hF0F0_F0F0); check("bypass_same_cycle", rd_a[31:0]);
        tick();
        we0 = 1'b0;
        #1;
        expect_v(32'hF0F0_F0F0); check("nobypass_next_cycle", rd_b[31:0]);

        // Write to entry 0
        we0 = 1'b1; wr0 = 5'd0; wd0 = 32'hFFFF_FFFF; ra = {5'd2, 5'd0};
        #1;
        expect_v(32'h0000_0000); check("zero_reg_same_cycle", rd_c[31:0]);
        expect_v(32'hFFFF_FFFF); check("entry0_bypass_a", rd_a[31:0]);
        tick();
        we0 = 1'b0;
        #1;
        expect_v(32'h0000_0000); check("zero_reg_after", rd_c[31:0]);
        expect_v(32'hFFFF_FFFF); check("entry0_stored_a", rd_a[31:0]);

        // Seed entry 20 and small-file entry 5 before the second reset
        we0 = 1'b1; wr0 = 5'd20; wd0 = 32'h0000_1234;
        we0_d = 1'b1; wr0_d = 3'd5; wd0_d = 32'h0000_0077;
        tick();
        we0 = 1'b0; we0_d = 1'b0; ra = {5'd0, 5'd20}; ra_d = {3'd3, 3'd0, 3'd7, 3'd5};
        #1;
        expect_v(32'h0000_1234); check("seed_entry20", rd_a[31:0]);
        expect_v(32'h0000_0077); check("seed_d_entry5", rd_d[31:0]);

        // Reset, then reset again ten cycles into the sweep while writing entry 20
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we0 = 1'b1; wr0 = 5'd20; wd0 = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        expect_v(32'd1); check("busy_after_midsweep_rst", {31'b0, busy_a});
        expect_v(32'd0); check("rd_gated_while_busy", rd_a[31:0]);
        count_busy(na, nb, nc, nd);
        we0 = 1'b0;
        #1;
        expect_v(32'd32); check("resweep_len_a", na);
        expect_v(32'd8);  check("resweep_len_d", nd);
        expect_v(32'h0000_0000); check("entry20_after_resweep", rd_a[31:0]);
        expect_v(32'h0000_0000); check("entry0_after_resweep", rd_a[63:32]);
        for (int k = 0; k < 4; k++) begin
            expect_v(32'h0000_0000); check("d_port_cleared", rd_d[k*32 +: 32]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the multi-cycle CPU datapath, replacing the fixed 32x32, two-read/one-write file. It adds configurable width, depth and read-port count, a second write port, optional hardwired zero register and same-cycle write-to-read bypass. It also has a hardware clear sequencer: after reset it zeroes every entry, one entry per clock, before accepting writes.

## Interface
- DATA_W, 32, bits per register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- N_READ, 2, number of read ports (1..4)
- ZERO_REG, 0, 1 = entry 0 reads as 0 and ignores writes
- BYPASS, 1, 1 = a read of an address written this cycle returns the write data
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset; starts the clear sweep
- we0  in  1  write enable, port 0
- wr0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1
- wr1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- ra  in  N_READ*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd  out  N_READ*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
- busy  out  1  high while the clear sweep runs; resets to 1

## Operation
- Sequencer FSM states: CLEAR and READY.
- Posedge with rst=1: state <= CLEAR and clr_idx <= 0.
  - Takes effect from any state, including mid-sweep; the sweep restarts at entry 0.
- CLEAR, per cycle:
  - mem[clr_idx] <= 0 and clr_idx increments.
  - When clr_idx == DEPTH-1, state <= READY.
  - clr_idx is ADDR_W bits wide and wraps to 0 on exit.
- busy = (state == CLEAR), driven from the register.
- Write ports in READY:
  - Port p writes mem[wrp] <= wdp when wep=1.
  - we0 and we1 targeting the same address: port 1 wins, port 0 is dropped.
  - ZERO_REG=1: writes to address 0 are dropped on both ports.
  - While busy, both write ports are ignored entirely.
- Read ports are combinational. Per port k:
  - busy=1: rd_k = 0.
  - ZERO_REG=1 and ra_k == 0: rd_k = 0.
  - BYPASS=1, READY, we1=1 and wr1 == ra_k: rd_k = wd1.
  - Otherwise, BYPASS=1, READY, we0=1 and wr0 == ra_k: rd_k = wd0.
  - Otherwise: rd_k = mem[ra_k].
- No arithmetic on data. Addresses are unsigned, and every ADDR_W value is a valid entry.
- Contents before the first reset are undefined. The CPU top asserts rst at power-up, and the old preload initial block is dropped.

## Timing
- Clear sweep: busy=1 on the posedge that samples rst=1.
  - Stays 1 for exactly DEPTH cycles after the last cycle with rst=1.
  - Falls on the edge that clears entry DEPTH-1.
- Write latency: 1 cycle. Data written at edge N is visible in mem from edge N onward.
  - BYPASS=0: a same-cycle read returns the old value.
- Read latency: 0 cycles (combinational from ra, mem, we, wr, wd).
- rst held high: clr_idx holds at 0, and entry 0 is rewritten with 0 each cycle.

## Structure
- Shared package register_file_pkg:
  - rf_state_t enum {RF_CLEAR, RF_READY}
  - default constants RF_DATA_W=32, RF_ADDR_W=5
- Sub-module rf_clear_seq: FSM plus clr_idx counter.
  - Inputs: clk, rst.
  - Outputs: busy, clr_we, clr_addr.
  - The top muxes clr_we and clr_addr onto the array write path.
- Top: storage array, write arbitration, N_READ generate-loop read muxes with bypass.

## Test plan
- Reset, defaults: pulse rst for 1 cycle.
  - busy=1 for exactly 32 cycles.
  - Then all 32 entries read 0, and rd = 0 during the sweep.
- Basic write: after the sweep, we0=1, wr0=3, wd0=32'h00000003.
  - Next cycle ra port 0 = 3 -> rd0 = 32'h00000003.
  - ra port 1 = 2 -> rd1 = 0.
- Write conflict: we0=we1=1, wr0=wr1=7, wd0=32'hAAAA_AAAA, wd1=32'h5555_5555.
  - Entry 7 = 32'h5555_5555.
  - Same cycle with BYPASS=1 and ra=7 -> rd = 32'h5555_5555.
- Bypass off: BYPASS=0, write 32'hF0F0F0F0 to entry 2 while reading entry 2.
  - Same-cycle rd = old value 0; next cycle rd = 32'hF0F0F0F0.
- Zero register: ZERO_REG=1, we0=1, wr0=0, wd0=32'hFFFF_FFFF.
  - Entry 0 reads 0 the same cycle and afterwards.
- Reset mid-sweep: rst again at sweep cycle 10, with we0=1 to entry 20 during the sweep.
  - busy stays 1 for 32 more cycles.
  - The write is ignored; entry 20 = 0.
  - Sweep with ADDR_W=3, N_READ=4: busy=1 for 8 cycles, and all 4 ports read 0 afterwards.
